// File: rtl/mem_pkg.sv
// Shared load/store encodings for the data memory and the control unit.
// Decodes funct3 into an access size and store legality.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_NONE
  } acc_size_e;

  // Size as seen by a load; SZ_NONE marks an illegal encoding.
  function automatic acc_size_e access_size(input logic [2:0] f3);
    acc_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_BYTE;
      F3_H, F3_HU: sz = SZ_HALF;
      F3_W:        sz = SZ_WORD;
      default:     sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword lane out of a memory word and
// sign- or zero-extends it to 32 bits according to funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_signed;

  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  assign half_sel  = lane[1] ? word[31:16] : word[15:0];
  assign is_signed = ~funct3[2];

  always_comb begin
    result = 32'h0;
    case (access_size(funct3))
      SZ_BYTE: result = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{is_signed & half_sel[15]}}, half_sel};
      SZ_WORD: result = word;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed, word-organised data memory: clocked stores with lane
// enables, combinational loads, fault decode and asynchronous clear.
module data_memory
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic [31:0] read_data,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  acc_size_e     size;
  logic          out_of_range;
  logic          misaligned;
  logic          load_bad;
  logic          store_bad;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic [31:0]   rd_word;
  logic [31:0]   ext_data;

  assign idx  = addr[AW+1:2];
  assign lane = addr[1:0];
  assign size = access_size(funct3);

  // Any bit above the array span means out of range; no wrap-around.
  assign out_of_range = |(addr >> (AW + 2));
  assign misaligned   = ((size == SZ_HALF) && lane[0]) ||
                        ((size == SZ_WORD) && (lane != 2'b00));

  assign load_bad  = out_of_range | misaligned | (size == SZ_NONE);
  assign store_bad = out_of_range | misaligned | ~is_store_f3(funct3);
  assign fault     = (mem_read & load_bad) | (mem_write & store_bad);

  always_comb begin
    be     = 4'b0000;
    wlanes = write_data;
    case (size)
      SZ_BYTE: begin
        be     = 4'b0001 << lane;
        wlanes = {4{write_data[7:0]}};
      end
      SZ_HALF: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{write_data[15:0]}};
      end
      SZ_WORD: begin
        be     = 4'b1111;
        wlanes = write_data;
      end
      default: begin
        be     = 4'b0000;
        wlanes = write_data;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
        end
      end
    end
  end

  // Read path sees the pre-edge contents, giving read-before-write.
  assign rd_word = mem[idx];

  load_extend u_load_extend (
    .word   (rd_word),
    .lane   (lane),
    .funct3 (funct3),
    .result (ext_data)
  );

  assign read_data = (mem_read && !fault) ? ext_data : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed plan values plus randomized
// traffic checked against a byte-array reference model.
module tb_data_memory;

  localparam int DEPTH  = 256;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] read_data;
  logic        fault;

  data_memory #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .write_data (write_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .read_data  (read_data),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        flt;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  byte unsigned ref_mem[NBYTES];
  int          checks = 0;
  int          errors = 0;

  // Bytes touched by an access; 0 means the encoding is illegal.
  function automatic int acc_bytes(input logic [2:0] f3, input bit is_store);
    int n;
    case (f3)
      3'b000: n = 1;
      3'b001: n = 2;
      3'b010: n = 4;
      3'b100: n = is_store ? 0 : 1;
      3'b101: n = is_store ? 0 : 2;
      default: n = 0;
    endcase
    return n;
  endfunction

  function automatic bit op_bad(input logic [2:0] f3, input logic [31:0] a, input bit is_store);
    int n;
    n = acc_bytes(f3, is_store);
    if (longint'(a) >= longint'(NBYTES)) return 1'b1;
    if (n == 0) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic model_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] a);
    return (rd && op_bad(f3, a, 1'b0)) || (wr && op_bad(f3, a, 1'b1));
  endfunction

  function automatic logic [31:0] model_read(input bit rd, input logic f,
                                             input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 32'h0;
    if (!rd || f) return 32'h0;
    n = acc_bytes(f3, 1'b0);
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8 * k));
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // One cycle of stimulus. use_k pushes the given constant expectation
  // instead of the model's; the model is updated either way.
  task automatic step(input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit pulse, input bit hold_low, input string tag,
                      input bit use_k, input logic [31:0] k_rd, input logic k_f);
    exp_t e;
    logic f;
    @(posedge clk);
    #1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    write_data = wd;
    if (hold_low) begin
      rst_n = 1'b0;
    end else if (pulse) begin
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
    end else begin
      rst_n = 1'b1;
    end
    if (hold_low || pulse) begin
      for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    end
    f = model_fault(rd, wr, f3, a);
    e.tag = tag;
    if (use_k) begin
      e.rd  = k_rd;
      e.flt = k_f;
    end else begin
      e.rd  = model_read(rd, f, f3, a);
      e.flt = f;
    end
    sbq.push_back(e);
    if (!hold_low && wr && !f) begin
      for (int k = 0; k < acc_bytes(f3, 1'b1); k++)
        ref_mem[int'(a) + k] = wd[8*k +: 8];
    end
  endtask

  task automatic dk(input bit rd, input bit wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd, input string tag,
                    input logic [31:0] k_rd, input logic k_f);
    step(rd, wr, f3, a, wd, 1'b0, 1'b0, tag, 1'b1, k_rd, k_f);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (read_data !== e.rd) begin
        errors++;
        $display("FAIL %s read_data: got %h expected %h", e.tag, read_data, e.rd);
      end
      checks++;
      if (fault !== e.flt) begin
        errors++;
        $display("FAIL %s fault: got %b expected %b", e.tag, fault, e.flt);
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [2:0]  rf;
    bit          rr, rw;
    rst_n      = 1'b1;
    addr       = 32'h0;
    write_data = 32'h0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b010;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;

    step(1, 0, 3'b010, 32'h10, 32'h0, 0, 1, "reset_lw", 1, 32'h0, 1'b0);
    dk(1, 0, 3'b010, 32'h10, 32'h0,          "post_reset_lw", 32'h0, 1'b0);
    dk(0, 0, 3'b010, 32'h10, 32'h0,          "idle",          32'h0, 1'b0);
    dk(0, 1, 3'b010, 32'h20, 32'hDEADBEEF,   "sw_20",         32'h0, 1'b0);
    dk(1, 0, 3'b010, 32'h20, 32'h0,          "lw_20",         32'hDEADBEEF, 1'b0);
    dk(1, 0, 3'b000, 32'h23, 32'h0,          "lb_23",         32'hFFFFFFDE, 1'b0);
    dk(1, 0, 3'b100, 32'h23, 32'h0,          "lbu_23",        32'h000000DE, 1'b0);
    dk(1, 0, 3'b001, 32'h20, 32'h0,          "lh_20",         32'hFFFFBEEF, 1'b0);
    dk(1, 0, 3'b101, 32'h22, 32'h0,          "lhu_22",        32'h0000DEAD, 1'b0);
    dk(0, 1, 3'b010, 32'h40, 32'h11223344,   "sw_40",         32'h0, 1'b0);
    dk(0, 1, 3'b000, 32'h41, 32'hA5A5A5AA,   "sb_41",         32'h0, 1'b0);
    dk(1, 0, 3'b010, 32'h40, 32'h0,          "lw_40_sb",      32'h1122AA44, 1'b0);
    dk(0, 1, 3'b001, 32'h42, 32'h0000BEEF,   "sh_42",         32'h0, 1'b0);
    dk(1, 0, 3'b010, 32'h40, 32'h0,          "lw_40_sh",      32'hBEEFAA44, 1'b0);
    dk(0, 1, 3'b010, 32'h45, 32'hFFFFFFFF,   "sw_45_misal",   32'h0, 1'b1);
    dk(1, 0, 3'b010, 32'h44, 32'h0,          "lw_44_intact",  32'h0, 1'b0);
    dk(1, 0, 3'b010, 32'h40, 32'h0,          "lw_40_intact",  32'hBEEFAA44, 1'b0);
    dk(1, 0, 3'b001, 32'h47, 32'h0,          "lh_47_misal",   32'h0, 1'b1);
    dk(1, 0, 3'b010, 32'h400, 32'h0,         "lw_400_oor",    32'h0, 1'b1);
    dk(1, 0, 3'b010, 32'h3FC, 32'h0,         "lw_3fc_edge",   32'h0, 1'b0);
    dk(1, 0, 3'b011, 32'h40, 32'h0,          "ld_f3_011",     32'h0, 1'b1);
    dk(0, 1, 3'b100, 32'h40, 32'h0,          "st_f3_100",     32'h0, 1'b1);
    dk(1, 0, 3'b010, 32'h40, 32'h0,          "lw_40_after",   32'hBEEFAA44, 1'b0);
    dk(1, 1, 3'b010, 32'h80, 32'h12345678,   "rw_80_old",     32'h0, 1'b0);
    dk(1, 0, 3'b010, 32'h80, 32'h0,          "lw_80_new",     32'h12345678, 1'b0);
    dk(0, 1, 3'b010, 32'h0,   32'hCAFEF00D,  "sw_0",          32'h0, 1'b0);
    dk(0, 1, 3'b010, 32'h3FC, 32'h89ABCDEF,  "sw_3fc",        32'h0, 1'b0);
    dk(1, 0, 3'b010, 32'h3FC, 32'h0,         "lw_3fc_set",    32'h89ABCDEF, 1'b0);
    step(1, 0, 3'b010, 32'h0, 32'h0, 1, 0, "lw_0_pulse", 1, 32'h0, 1'b0);
    dk(1, 0, 3'b010, 32'h3FC, 32'h0,         "lw_3fc_clr",    32'h0, 1'b0);
    step(0, 1, 3'b010, 32'h10, 32'h55AA55AA, 0, 1, "sw_in_reset", 1, 32'h0, 1'b0);
    dk(1, 0, 3'b010, 32'h10, 32'h0,          "lw_10_lost",    32'h0, 1'b0);
    dk(0, 1, 3'b010, 32'h10, 32'h0BADF00D,   "sw_first_edge", 32'h0, 1'b0);
    dk(1, 0, 3'b010, 32'h10, 32'h0,          "lw_10_first",   32'h0BADF00D, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) ra = $urandom;
      else ra = $urandom_range(0, NBYTES + 15);
      if ($urandom_range(0, 1) == 0) ra = ra & 32'hFFFF_FFFC;
      rf = 3'($urandom_range(0, 7));
      rr = $urandom_range(0, 1) == 1;
      rw = $urandom_range(0, 2) != 0;
      step(rr, rw, rf, ra, $urandom, $urandom_range(0, 299) == 0,
           $urandom_range(0, 299) == 0, "random", 0, 32'h0, 1'b0);
    end

    repeat (4) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
